fwd_hazard_unit: RTL and testbench

//   Sequential forwarding/hazard controller of the 5-stage pipelined CPU. It tracks the destination

---
 rtl/fwd_pkg.sv | 26 ++
 rtl/fwd_match.sv | 42 ++++
 rtl/fwd_hazard_unit.sv | 138 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
//   Shared definitions for the forwarding / hazard controller.
//   - FWD_* : 2-bit operand mux select codes
//   - stage_rec_t : per-stage record of an in-flight instruction
//   - BUBBLE_REC : record inserted into EX on a stall or flush
//   - REG_W : register-number width used by the records
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF     = 2'b00;  // register file value
    localparam logic [1:0] FWD_EXMEM  = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] FWD_MEMWB  = 2'b10;  // MEM/WB write data
    localparam logic [1:0] FWD_POSTWB = 2'b11;  // post-WB register

    typedef struct packed {
        logic [REG_W-1:0] dst;  // destination register number
        logic             we;   // instruction writes the register file
        logic             ld;   // instruction is a load
    } stage_rec_t;

    localparam stage_rec_t BUBBLE_REC = '{dst: '0, we: 1'b0, ld: 1'b0};

endpackage

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
//   Combinational priority compare of one source register against the
//   in-flight producers. The nearest producer wins (EX, then MEM, then WB).
//   Register 0 is hard-wired zero and never forwarded.
// Ports:
//   r        in   source register number of the ID instruction
//   ex_dst   in   destination of the instruction in EX
//   ex_we    in   EX instruction writes the register file
//   mem_dst  in   destination of the instruction in MEM
//   mem_we   in   MEM instruction writes the register file
//   wb_dst   in   destination of the instruction in WB
//   wb_we    in   WB instruction writes the register file
//   sel      out  2-bit operand mux select (FWD_* codes)
// -----------------------------------------------------------------------------
module fwd_match
    import fwd_pkg::*;
(
    input  logic [REG_W-1:0] r,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_we,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_we,
    input  logic [REG_W-1:0] wb_dst,
    input  logic             wb_we,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_RF;
        if (r != '0) begin
            if (ex_we && (ex_dst == r)) begin
                sel = FWD_EXMEM;
            end else if (mem_we && (mem_dst == r)) begin
                sel = FWD_MEMWB;
            end else if (wb_we && (wb_dst == r)) begin
                sel = FWD_POSTWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   Forwarding / load-use hazard controller of the 5-stage pipeline.
//   Tracks {dst, we, ld} of the instructions in EX, MEM and WB. Operand
//   selects are computed while the consumer sits in ID and registered on the
//   edge that moves it into EX, so they line up with the EX operands.
//   Selects are only computed against EX/MEM/WB: a producer that was in WB
//   when the consumer sat in ID is read from the datapath's post-WB register
//   (code 11), so no record beyond WB is needed here.
//
// Optional feature (macro FWD_STATS_EN): adds saturating statistics counters
//   stall_cnt_o (cycles with stall_o high) and fwd_cnt_o (edges loading a
//   non-00 select into either operand).
//
// Parameters:
//   REG_ADDR_W  register-number width (must equal fwd_pkg::REG_W)
//   CNT_W       statistics counter width (FWD_STATS_EN only)
// Ports:
//   clk_i          in   clock, all state on rising edge
//   rst_i          in   asynchronous active-low reset
//   id_rs_i        in   rs of the ID instruction
//   id_rt_i        in   rt of the ID instruction
//   id_dst_i       in   destination register of the ID instruction
//   id_regwrite_i  in   ID instruction writes the register file
//   id_memread_i   in   ID instruction is a load
//   flush_i        in   kill the ID instruction; a bubble enters EX
//   fwd_a_sel_o    out  operand-A select for the EX instruction (registered)
//   fwd_b_sel_o    out  operand-B select for the EX instruction (registered)
//   stall_o        out  load-use stall of PC and IF/ID (combinational)
//   stall_cnt_o    out  stall cycle counter (FWD_STATS_EN only)
//   fwd_cnt_o      out  forwarding event counter (FWD_STATS_EN only)
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_dst_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
`ifdef FWD_STATS_EN
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      fwd_cnt_o,
`endif
    output logic                  stall_o
);

    stage_rec_t ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;
    stage_rec_t id_rec;

    logic [1:0] a_nxt;
    logic [1:0] b_nxt;
    logic       bubble;

    assign id_rec = '{dst: id_dst_i, we: id_regwrite_i, ld: id_memread_i};

    fwd_match u_match_a (
        .r       (id_rs_i),
        .ex_dst  (ex_q.dst),
        .ex_we   (ex_q.we),
        .mem_dst (mem_q.dst),
        .mem_we  (mem_q.we),
        .wb_dst  (wb_q.dst),
        .wb_we   (wb_q.we),
        .sel     (a_nxt)
    );

    fwd_match u_match_b (
        .r       (id_rt_i),
        .ex_dst  (ex_q.dst),
        .ex_we   (ex_q.we),
        .mem_dst (mem_q.dst),
        .mem_we  (mem_q.we),
        .wb_dst  (wb_q.dst),
        .wb_we   (wb_q.we),
        .sel     (b_nxt)
    );

    // Load in EX feeding the ID instruction: its data only exists after MEM,
    // so hold ID one cycle. A flush kills the consumer, so it overrides.
    assign stall_o = ex_q.ld && ex_q.we && (ex_q.dst != '0) &&
                     ((ex_q.dst == id_rs_i) || (ex_q.dst == id_rt_i)) && !flush_i;

    assign bubble = stall_o || flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q        <= BUBBLE_REC;
            mem_q       <= BUBBLE_REC;
            wb_q        <= BUBBLE_REC;
            fwd_a_sel_o <= FWD_RF;
            fwd_b_sel_o <= FWD_RF;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble) begin
                ex_q        <= BUBBLE_REC;
                fwd_a_sel_o <= FWD_RF;
                fwd_b_sel_o <= FWD_RF;
            end else begin
                ex_q        <= id_rec;
                fwd_a_sel_o <= a_nxt;
                fwd_b_sel_o <= b_nxt;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic fwd_event;

    assign fwd_event = !bubble && ((a_nxt != FWD_RF) || (b_nxt != FWD_RF));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (fwd_event && (fwd_cnt_o != '1)) begin
                fwd_cnt_o <= fwd_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Directed bench for fwd_hazard_unit. Inputs change one time unit after a
//   rising edge; stall_o is checked before the next edge, registered selects
//   one time unit after it. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic [4:0] id_dst_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       flush_i;
    logic [1:0] fwd_a_sel_o;
    logic [1:0] fwd_b_sel_o;
    logic       stall_o;
`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt_o;
    logic [15:0] fwd_cnt_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // clock
    always #5 clk_i = ~clk_i;

    fwd_hazard_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_dst_i      (id_dst_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_a_sel_o   (fwd_a_sel_o),
        .fwd_b_sel_o   (fwd_b_sel_o),
`ifdef FWD_STATS_EN
        .stall_cnt_o   (stall_cnt_o),
        .fwd_cnt_o     (fwd_cnt_o),
`endif
        .stall_o       (stall_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive the ID instruction
    task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                      input logic we, input logic ld, input logic fl);
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_dst_i      = dst;
        id_regwrite_i = we;
        id_memread_i  = ld;
        flush_i       = fl;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic nop();
        id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) nop();
    endtask

    // producer of $3, (d-1) nops, then consumer reading $3 on rs
    task automatic distance(input int d, input logic [1:0] exp_a, input string tag);
        id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 1; i < d; i++) nop();
        id(5'd3, 5'd4, 5'd7, 1'b0, 1'b0, 1'b0);
        tick();
        chk({tag, "_a"}, 16'(fwd_a_sel_o), 16'(exp_a));
        chk({tag, "_b"}, 16'(fwd_b_sel_o), 16'd0);
        drain();
    endtask

    initial begin
        // reset
        rst_i = 1'b0;
        id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_a", 16'(fwd_a_sel_o), 16'd0);
        chk("rst_b", 16'(fwd_b_sel_o), 16'd0);
        chk("rst_stall", 16'(stall_o), 16'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // 1. forwarding distance 1..4
        distance(1, 2'b01, "dist1");
        distance(2, 2'b10, "dist2");
        distance(3, 2'b11, "dist3");
        distance(4, 2'b00, "dist4");
        // distance 1 on operand B
        id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        id(5'd4, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        tick();
        chk("dist1_rt_a", 16'(fwd_a_sel_o), 16'd0);
        chk("dist1_rt_b", 16'(fwd_b_sel_o), 16'd1);
        drain();

        // 2. load-use on rs
        id(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        #1;
        chk("lw_nostall", 16'(stall_o), 16'd0);
        tick();
        id(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall", 16'(stall_o), 16'd1);
        tick();
        chk("lu_bubble_a", 16'(fwd_a_sel_o), 16'd0);
        chk("lu_bubble_b", 16'(fwd_b_sel_o), 16'd0);
        chk("lu_stall_1cyc", 16'(stall_o), 16'd0);
        tick();
        chk("lu_fwd_a", 16'(fwd_a_sel_o), 16'd2);
        chk("lu_fwd_b", 16'(fwd_b_sel_o), 16'd0);
        drain();
        // load-use on rt
        id(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_rt_stall", 16'(stall_o), 16'd1);
        tick();
        tick();
        chk("lu_rt_fwd_b", 16'(fwd_b_sel_o), 16'd2);
        drain();

        // 3. register 0 never forwarded, lw $0 never stalls
        id(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        id(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        chk("r0_a", 16'(fwd_a_sel_o), 16'd0);
        chk("r0_b", 16'(fwd_b_sel_o), 16'd0);
        drain();
        id(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lw0_stall", 16'(stall_o), 16'd0);
        tick();
        chk("lw0_a", 16'(fwd_a_sel_o), 16'd0);
        chk("lw0_b", 16'(fwd_b_sel_o), 16'd0);
        drain();

        // 4. flush beats load-use stall
        id(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1);
        #1;
        chk("flush_stall", 16'(stall_o), 16'd0);
        tick();
        chk("flush_a", 16'(fwd_a_sel_o), 16'd0);
        chk("flush_b", 16'(fwd_b_sel_o), 16'd0);
        nop();
        // the killed instruction ($6) must not be seen as a producer
        id(5'd6, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);
        tick();
        chk("flush_gone_a", 16'(fwd_a_sel_o), 16'd0);
        drain();

        // 5. nearest producer wins, rs==rt
        id(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        id(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        id(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        chk("near_a", 16'(fwd_a_sel_o), 16'd1);
        chk("near_b", 16'(fwd_b_sel_o), 16'd1);
        drain();

        // 6. asynchronous reset mid-stream
        id(5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        id(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        id(5'd9, 5'd8, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        chk("pre_rst_a", 16'(fwd_a_sel_o), 16'd1);
        chk("pre_rst_b", 16'(fwd_b_sel_o), 16'd2);
        id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 rst_i = 1'b0;
        #1;
        chk("async_rst_a", 16'(fwd_a_sel_o), 16'd0);
        chk("async_rst_b", 16'(fwd_b_sel_o), 16'd0);
        chk("async_rst_stall", 16'(stall_o), 16'd0);
`ifdef FWD_STATS_EN
        chk("rst_stall_cnt", stall_cnt_o, 16'd0);
        chk("rst_fwd_cnt", fwd_cnt_o, 16'd0);
`endif
        #2 rst_i = 1'b1;
        id(5'd10, 5'd9, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        chk("post_rst_a", 16'(fwd_a_sel_o), 16'd0);
        chk("post_rst_b", 16'(fwd_b_sel_o), 16'd0);

`ifdef FWD_STATS_EN
        // one load-use stall then one forwarded consumer
        drain();
        id(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("stats_stall_cnt", stall_cnt_o, 16'd1);
        chk("stats_fwd_cnt", fwd_cnt_o, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
